// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control FSM sequencing fetch/decode/execute/memory/writeback
module multicycle_ctrl #(
   parameter int RESET_PC_HOLD = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        branch_taken,
   output logic        mem_req,
   output logic        mem_we,
   output logic        ir_we,
   output logic        mdr_we,
   output logic        pc_we,
   output logic        pc_sel,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic        alu_src_a,
   output logic        alu_src_b,
   output logic [3:0]  alu_op,
   output logic [1:0]  imm_sel,
   output logic [19:0] imm_field,
   output logic        illegal
);
   localparam int CW = (RESET_PC_HOLD > 1) ? $clog2(RESET_PC_HOLD) : 1;
   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
      OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
      OP_IMM = 7'b0010011, OP_OP = 7'b0110011;
   typedef enum logic [2:0] {RESET, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
   state_t          state;
   logic [CW-1:0]   hold_cnt;
   logic [6:0]      opc;
   logic [2:0]      f3;
   logic            f7;
   logic [6:0]      op_i;
   logic            known;
   logic [1:0]      imm_sel_d;
   logic [19:0]     imm_d;
   logic            is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, alu_act;
   // immediate assembly works on the live instruction so it can be latched leaving DECODE
   always_comb begin
      op_i      = instr[6:0];
      known     = op_i inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_OP};
      imm_sel_d = (op_i == OP_BR) ? 2'd1 :
                  (op_i == OP_LUI || op_i == OP_AUIPC) ? 2'd2 :
                  (op_i == OP_JAL) ? 2'd3 : 2'd0;
      imm_d     = (op_i == OP_LUI || op_i == OP_AUIPC) ? instr[31:12] :
                  (op_i == OP_JAL) ? {instr[31], instr[19:12], instr[20], instr[30:21]} :
                  (op_i == OP_BR) ? {8'd0, instr[31], instr[7], instr[30:25], instr[11:8]} :
                  (op_i == OP_ST) ? {8'd0, instr[31:25], instr[11:7]} :
                  (op_i == OP_IMM || op_i == OP_LD || op_i == OP_JALR) ? {8'd0, instr[31:20]} : 20'd0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RESET;
         hold_cnt  <= '0;
         opc       <= '0;
         f3        <= '0;
         f7        <= 1'b0;
         imm_sel   <= '0;
         imm_field <= '0;
      end else begin
         case (state)
            RESET: begin
               if (hold_cnt == CW'(RESET_PC_HOLD - 1)) state <= FETCH;
               else hold_cnt <= hold_cnt + 1'b1;
            end
            FETCH: if (mem_ready) state <= DECODE;
            DECODE: begin
               opc   <= op_i;
               f3    <= instr[14:12];
               f7    <= instr[30];
               state <= known ? EXEC : TRAP;
               if (known) begin
                  imm_sel   <= imm_sel_d;
                  imm_field <= imm_d;
               end
            end
            EXEC: state <= (opc == OP_BR) ? FETCH : (opc == OP_LD || opc == OP_ST) ? MEM : WB;
            MEM: if (mem_ready) state <= (opc == OP_ST) ? FETCH : WB;
            WB: state <= FETCH;
            default: state <= TRAP;
         endcase
      end
   end
   always_comb begin
      is_lui    = opc == OP_LUI;
      is_auipc  = opc == OP_AUIPC;
      is_jal    = opc == OP_JAL;
      is_jalr   = opc == OP_JALR;
      is_br     = opc == OP_BR;
      is_ld     = opc == OP_LD;
      is_st     = opc == OP_ST;
      is_opi    = opc == OP_IMM;
      is_op     = opc == OP_OP;
      // ALU controls are held past EXEC so the datapath result stays stable through MEM/WB
      alu_act   = state inside {EXEC, MEM, WB};
      mem_req   = state == FETCH || state == MEM;
      mem_we    = state == MEM && is_st;
      ir_we     = state == FETCH && mem_ready;
      mdr_we    = state == MEM && is_ld && mem_ready;
      pc_we     = (state == EXEC && is_br) || (state == MEM && is_st && mem_ready) || state == WB;
      pc_sel    = (state == EXEC && is_br) ? branch_taken : (state == WB && (is_jal || is_jalr));
      reg_we    = state == WB;
      wb_sel    = (state != WB) ? 2'd0 : is_ld ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;
      alu_src_a = alu_act && (is_auipc || is_jal || is_br);
      alu_src_b = alu_act && !(is_op || is_lui);
      alu_op    = !alu_act ? 4'd0 : is_op ? {f7, f3} : is_opi ? {f7 && f3 == 3'b101, f3} : 4'd0;
      illegal   = state == TRAP;
   end
endmodule
